// File: rtl/fifo_stream_drain_if.sv
// Handshake bundle for fifo_stream_drain: FIFO read side plus the
// valid/ready output stream and status counters.
interface fifo_stream_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
);
  localparam int LVL_W = $clog2(BUF_DEPTH) + 1;

  logic                  drain_en;
  logic                  flush;
  logic                  fifo_empty;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LVL_W-1:0]      buf_level;
  logic [CNT_WIDTH-1:0]  words_out;

  // Drain block side
  modport master (
    input  drain_en, flush, fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd, out_valid, out_data, buf_level, words_out
  );

  // Environment side (FIFO source plus downstream sink)
  modport slave (
    output drain_en, flush, fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd, out_valid, out_data, buf_level, words_out
  );
endinterface

// File: rtl/fifo_stream_drain.sv
// Read-side consumer for fifo_ctrl: issues read strobes while there is
// room in a small prefetch buffer, captures the data returned one cycle
// later, and presents it on a valid/ready stream at one word per clock.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic                clk,
  input logic                reset,
  fifo_stream_drain_if.master bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_inflight;
  logic                  r_drop;
  logic [CNT_WIDTH-1:0]  r_words_out;

  logic                  w_rd;
  logic                  w_push;
  logic                  w_pop;
  logic [LVL_W:0]        w_committed;

  // Issue/return/handshake decisions; fifo_rd looks only at registered
  // occupancy, never at out_ready, so no combinational path exists from
  // the downstream sink back to the FIFO.
  always_comb begin
    w_committed = {1'b0, r_level} + {{LVL_W{1'b0}}, r_inflight};
    // Reset also blocks issue so no word is ever in flight across reset.
    w_rd   = ~reset & bus.drain_en & ~bus.fifo_empty & ~bus.flush &
             (w_committed < (LVL_W+1)'(BUF_DEPTH));
    // r_drop only matters for a read that raced a flush; the issue rule
    // already masks those, so it is a second line of defence.
    w_push = r_inflight & ~r_drop;
    w_pop  = (r_level != '0) & bus.out_ready;
  end

  // Pointer, level, in-flight and handshake counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_inflight  <= 1'b0;
      r_drop      <= 1'b0;
      r_words_out <= '0;
    end else begin
      r_inflight  <= w_rd;
      r_drop      <= bus.flush;
      r_words_out <= r_words_out + CNT_WIDTH'(w_pop);
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      end
    end
  end

  // Prefetch storage; cleared on reset so out_data starts at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else if (w_push && !bus.flush) begin
      r_buf[r_wr_ptr] <= bus.fifo_rd_data;
    end
  end

  assign bus.fifo_rd   = w_rd;
  assign bus.out_valid = (r_level != '0);
  assign bus.out_data  = r_buf[r_rd_ptr];
  assign bus.buf_level = r_level;
  assign bus.words_out = r_words_out;
endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: a behavioural FIFO source plus a queue
// model of the buffer feed a scoreboard; a monitor checks every cycle.
module tb_fifo_stream_drain;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int CW_S  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_stream_drain_if #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW))   bus   ();
  fifo_stream_drain_if #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW_S)) bus_s ();

  fifo_stream_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  // Narrow-counter copy sharing the same stimulus, for the wrap check.
  fifo_stream_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW_S)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  assign bus_s.drain_en     = bus.drain_en;
  assign bus_s.flush        = bus.flush;
  assign bus_s.fifo_empty   = bus.fifo_empty;
  assign bus_s.fifo_rd_data = bus.fifo_rd_data;
  assign bus_s.out_ready    = bus.out_ready;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: words the buffer should hold, in order.
  logic [DW-1:0] exp_q[$];
  int unsigned   exp_count = 0;
  logic          pend = 1'b0;
  logic [DW-1:0] pend_word = '0;
  bit            armed = 1'b0;
  bit            use_cycle = 1'b0;
  int unsigned   cyc = 0;
  logic          smp_reset = 1'b1;
  logic          smp_rd = 1'b0;
  logic          smp_flush = 1'b0;
  logic          exp_rd;

  // Monitor: compare outputs against the model, pop on handshake.
  always @(negedge clk) begin
    smp_reset = reset;
    smp_rd    = bus.fifo_rd;
    smp_flush = bus.flush;
    if (armed) begin
      // Issue allowed only while buffered plus outstanding words fit.
      exp_rd = !reset && bus.drain_en && !bus.fifo_empty && !bus.flush &&
               (exp_q.size() + int'(pend) < DEPTH);
      chk("fifo_rd",     32'(bus.fifo_rd),   32'(exp_rd));
      chk("buf_level",   32'(bus.buf_level), 32'(exp_q.size()));
      chk("out_valid",   32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("words_out",   32'(bus.words_out), exp_count % (1 << CW));
      chk("words_out_4", 32'(bus_s.words_out), exp_count % (1 << CW_S));
      if (exp_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
      if (!reset && bus.out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        exp_count++;
      end
    end
    if (reset) exp_count = 0;
  end

  // Source and buffer model: apply the clock edge, then return read data.
  always @(posedge clk) begin
    cyc++;
    if (smp_reset || smp_flush) exp_q.delete();
    else if (pend) exp_q.push_back(pend_word);
    pend = smp_rd && !smp_reset && !smp_flush;
    #1;
    if (pend) begin
      pend_word = use_cycle ? cyc[DW-1:0] : DW'($urandom);
      bus.fifo_rd_data = pend_word;
    end else begin
      bus.fifo_rd_data = DW'($urandom);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) sync();
  endtask

  initial begin
    bus.drain_en = 1'b1;
    bus.flush = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.out_ready = 1'b1;
    bus.fifo_rd_data = '0;
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    armed = 1'b1;
    use_cycle = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.buf_level), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_words", 32'(bus.words_out), 32'd0);
    sync();

    // Streaming, one word per cycle.
    cycles(110);
    @(negedge clk);
    chk("stream_level_le1", 32'(bus.buf_level <= 1), 32'd1);
    sync();

    // Backpressure fills the buffer, then releases.
    use_cycle = 1'b0;
    bus.out_ready = 1'b0;
    cycles(10);
    @(negedge clk);
    chk("bp_level", 32'(bus.buf_level), 32'(DEPTH));
    chk("bp_rd",    32'(bus.fifo_rd),   32'd0);
    sync();
    bus.out_ready = 1'b1;
    cycles(20);

    // Empty source, then a single-cycle non-empty window.
    bus.fifo_empty = 1'b1;
    cycles(8);
    @(negedge clk);
    chk("empty_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_rd",    32'(bus.fifo_rd),   32'd0);
    sync();
    bus.fifo_empty = 1'b0;
    sync();
    bus.fifo_empty = 1'b1;
    cycles(6);

    // Flush with level 3 and a word in flight.
    bus.out_ready = 1'b0;
    bus.fifo_empty = 1'b0;
    cycles(4);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("pre_flush_level", 32'(bus.buf_level), 32'd3);
    sync();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("post_flush_level", 32'(bus.buf_level), 32'd0);
    chk("post_flush_valid", 32'(bus.out_valid), 32'd0);
    sync();
    bus.out_ready = 1'b1;
    cycles(10);

    // drain_en toggling with random backpressure, gaps and rare flushes.
    for (int i = 0; i < 300; i++) begin
      bus.drain_en   = ((i / 2) % 2) == 0;
      bus.out_ready  = 1'($urandom_range(0, 1));
      bus.fifo_empty = ($urandom_range(0, 4) == 0);
      bus.flush      = ($urandom_range(0, 39) == 0);
      sync();
    end
    bus.drain_en = 1'b1;
    bus.flush = 1'b0;
    bus.fifo_empty = 1'b0;

    // Reset mid-stream, then stream enough to wrap the narrow counter.
    for (int i = 0; i < 20; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      sync();
    end
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_level", 32'(bus.buf_level), 32'd0);
    chk("mid_rst_data",  32'(bus.out_data),  32'd0);
    chk("mid_rst_words", 32'(bus.words_out), 32'd0);
    sync();
    bus.out_ready = 1'b1;
    cycles(40);
    bus.fifo_empty = 1'b1;
    cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
